// File: rtl/ecc_148_wr_enc.sv
// Write-side SECDED encoder: two-stage valid/ready pipeline with duplicated parity
// generation for encoder self-check. Optional error injection under ECC_148_WR_ERR_INJ_EN.

module ecc_148_cal #(
   parameter int DATA_WIDTH   = 148,
   parameter int PARITY_WIDTH = 9
) (
   input  logic                    bypass,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   output logic [PARITY_WIDTH-1:0] parity_out
);

   localparam int HAM_WIDTH = PARITY_WIDTH - 1;

   logic [HAM_WIDTH-1:0] ham;
   logic [15:0]          pos;
   logic                 overall;

   // Data bit i occupies the i-th non-power-of-two codeword position (3,5,6,7,9,...).
   always_comb begin
      ham = '0;
      pos = 16'd3;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         for (int k = 0; k < HAM_WIDTH; k++) begin
            ham[k] = ham[k] ^ (data_in[i] & pos[k]);
         end
         pos = pos + 16'd1;
         if ((pos & (pos - 16'd1)) == 16'd0) begin
            pos = pos + 16'd1;
         end
      end
   end

   assign overall    = (^data_in) ^ (^ham);
   assign parity_out = bypass ? parity_in : {overall, ham};

endmodule

module ecc_148_wr_enc #(
   parameter int DATA_WIDTH   = 148,
   parameter int PARITY_WIDTH = 9,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ecc_fault_detc_en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   data_in,
`ifdef ECC_148_WR_ERR_INJ_EN
   input  logic                    inj_sbit,
   input  logic                    inj_dbit,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [PARITY_WIDTH-1:0] parity_out,
   output logic                    ecc_fault,
   output logic                    fault_sticky,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   input  logic                    fault_clr
);

   logic                    s1Valid_q, s1Valid_d;
   logic [DATA_WIDTH-1:0]   s1Data_q, s1Data_d;
   logic                    s2Valid_q, s2Valid_d;
   logic [DATA_WIDTH-1:0]   s2Data_q, s2Data_d;
   logic [PARITY_WIDTH-1:0] s2Par_q, s2Par_d;
   logic                    s2Fault_q, s2Fault_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    sticky_q, sticky_d;

   logic                    s1Adv, s2Adv;
   logic [PARITY_WIDTH-1:0] par0, par1;
   logic                    faultD;
   logic [DATA_WIDTH-1:0]   s1Word;
   logic                    outXferFault;

   ecc_148_cal #(
      .DATA_WIDTH   (DATA_WIDTH),
      .PARITY_WIDTH (PARITY_WIDTH)
   ) u_cal0 (
      .bypass     (1'b0),
      .data_in    (s1Data_q),
      .parity_in  ({PARITY_WIDTH{1'b0}}),
      .parity_out (par0)
   );

   ecc_148_cal #(
      .DATA_WIDTH   (DATA_WIDTH),
      .PARITY_WIDTH (PARITY_WIDTH)
   ) u_cal1 (
      .bypass     (1'b0),
      .data_in    (s1Data_q),
      .parity_in  ({PARITY_WIDTH{1'b0}}),
      .parity_out (par1)
   );

   assign s2Adv    = ~s2Valid_q | out_ready;
   assign s1Adv    = ~s1Valid_q | s2Adv;
   assign in_ready = s1Adv;
   assign faultD   = ecc_fault_detc_en & (par0 != par1);

`ifdef ECC_148_WR_ERR_INJ_EN
   logic [1:0]            s1Inj_q, s1Inj_d;
   logic [1:0]            injBits;
   logic [DATA_WIDTH-1:0] injMask;

   // Injection flips the emitted data only; parity was already taken from clean S1 data.
   assign injBits = s1Inj_q[1] ? 2'b11 : (s1Inj_q[0] ? 2'b01 : 2'b00);
   assign injMask = {{(DATA_WIDTH-2){1'b0}}, injBits};
   assign s1Word  = s1Data_q ^ injMask;

   always_comb begin
      s1Inj_d = s1Inj_q;
      if (s1Adv) begin
         s1Inj_d = {inj_dbit, inj_sbit};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Inj_q <= 2'b00;
      end else begin
         s1Inj_q <= s1Inj_d;
      end
   end
`else
   assign s1Word = s1Data_q;
`endif

   // A stage reloads whenever it can advance, so bubbles propagate as well as words.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Data_d  = s1Data_q;
      s2Valid_d = s2Valid_q;
      s2Data_d  = s2Data_q;
      s2Par_d   = s2Par_q;
      s2Fault_d = s2Fault_q;
      if (s1Adv) begin
         s1Valid_d = in_valid;
         s1Data_d  = data_in;
      end
      if (s2Adv) begin
         s2Valid_d = s1Valid_q;
         s2Data_d  = s1Word;
         s2Par_d   = par0;
         s2Fault_d = faultD;
      end
   end

   assign outXferFault = s2Valid_q & out_ready & s2Fault_q;

   // Clear beats a concurrent fault; the count saturates instead of wrapping.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (fault_clr) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
      end else if (outXferFault) begin
         sticky_d = 1'b1;
         if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Data_q  <= '0;
         s2Valid_q <= 1'b0;
         s2Data_q  <= '0;
         s2Par_q   <= '0;
         s2Fault_q <= 1'b0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Data_q  <= s1Data_d;
         s2Valid_q <= s2Valid_d;
         s2Data_q  <= s2Data_d;
         s2Par_q   <= s2Par_d;
         s2Fault_q <= s2Fault_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
      end
   end

   assign out_valid    = s2Valid_q;
   assign data_out     = s2Data_q;
   assign parity_out   = s2Par_q;
   assign ecc_fault    = s2Fault_q;
   assign fault_sticky = sticky_q;
   assign fault_cnt    = cnt_q;

endmodule
